// File: rtl/elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : elevator_car_ctrl
// Description : Car controller at the consumer end of the request queue.
//               Steps the car one level per travel period toward the queue
//               head, serves queued levels en route, and holds the door open
//               for a fixed dwell at each stop. 'arrive' is the one-cycle pop
//               strobe back to the queue register.
//               Optional build macro DOOR_HOLD_EN: door_hold keeps the door
//               open while asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_car_ctrl #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] queue,
    input  logic [2:0] tail,
    input  logic       stop_at_pos_lvl,
    input  logic       door_hold,
    output logic [1:0] pos_lvl,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open,
    output logic       arrive
);

    // One shared timer covers both the travel and the door dwell.
    localparam int c_TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int c_TW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_TW-1:0] c_TRAVEL_LOAD = c_TW'(TRAVEL_CYCLES - 1);
    localparam logic [c_TW-1:0] c_DOOR_LOAD   = c_TW'(DOOR_CYCLES - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_MOVE  = 2'd1;
    localparam logic [1:0] c_S_CHECK = 2'd2;
    localparam logic [1:0] c_S_DOOR  = 2'd3;

    localparam logic [1:0] c_LVL_A = 2'd0;
    localparam logic [1:0] c_LVL_D = 2'd3;

    logic [1:0]      r_state;
    logic [c_TW-1:0] r_timer;
    logic [1:0]      r_pos;
    logic            r_moving;
    logic            r_dir_up;
    logic            r_door_open;
    logic            r_arrive;

    logic       w_tail_nz;
    logic [1:0] w_target;
    logic       w_dir_up;
    logic       w_at_target;
    logic [1:0] w_step_pos;
    logic       w_door_hold;
    logic       w_unused;

    assign w_tail_nz   = |tail;
    assign w_target    = queue[1:0];
    assign w_dir_up    = (w_target > r_pos);
    assign w_at_target = (w_target == r_pos);

`ifdef DOOR_HOLD_EN
    assign w_door_hold = door_hold;
    assign w_unused    = ^queue[7:2];
`else
    // Hold button has no effect in this build.
    assign w_door_hold = 1'b0;
    assign w_unused    = ^{queue[7:2], door_hold};
`endif

    // Next position after one step; saturates at the end levels instead of wrapping.
    always_comb begin
        w_step_pos = r_pos;
        if (r_dir_up) begin
            if (r_pos != c_LVL_D) w_step_pos = r_pos + 2'd1;
        end else begin
            if (r_pos != c_LVL_A) w_step_pos = r_pos - 2'd1;
        end
    end

    // Car state machine; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_timer     <= '0;
            r_pos       <= c_LVL_A;
            r_moving    <= 1'b0;
            r_dir_up    <= 1'b1;
            r_door_open <= 1'b0;
            r_arrive    <= 1'b0;
        end else begin
            r_arrive <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_tail_nz) begin
                        if (stop_at_pos_lvl) begin
                            r_state     <= c_S_DOOR;
                            r_door_open <= 1'b1;
                            r_arrive    <= 1'b1;
                            r_timer     <= c_DOOR_LOAD;
                        end else if (!w_at_target) begin
                            r_state  <= c_S_MOVE;
                            r_moving <= 1'b1;
                            r_dir_up <= w_dir_up;
                            r_timer  <= c_TRAVEL_LOAD;
                        end
                    end
                end
                c_S_MOVE: begin
                    if (r_timer == '0) begin
                        r_pos    <= w_step_pos;
                        r_moving <= 1'b0;
                        r_state  <= c_S_CHECK;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                c_S_CHECK: begin
                    if (stop_at_pos_lvl) begin
                        r_state     <= c_S_DOOR;
                        r_door_open <= 1'b1;
                        r_arrive    <= 1'b1;
                        r_timer     <= c_DOOR_LOAD;
                    end else if (!w_tail_nz || w_at_target) begin
                        // Target at current level with no stop is inconsistent input: park.
                        r_state <= c_S_IDLE;
                    end else begin
                        r_state  <= c_S_MOVE;
                        r_moving <= 1'b1;
                        r_dir_up <= w_dir_up;
                        r_timer  <= c_TRAVEL_LOAD;
                    end
                end
                c_S_DOOR: begin
                    if (w_door_hold) begin
                        r_timer <= c_DOOR_LOAD;
                    end else if (r_timer == '0) begin
                        r_state     <= c_S_IDLE;
                        r_door_open <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_S_IDLE;
                    r_moving    <= 1'b0;
                    r_door_open <= 1'b0;
                end
            endcase
        end
    end

    assign pos_lvl   = r_pos;
    assign moving    = r_moving;
    assign dir_up    = r_dir_up;
    assign door_open = r_door_open;
    assign arrive    = r_arrive;

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_car_ctrl
// Description : Self-checking bench for elevator_car_ctrl. A small queue
//               environment feeds the car; an arithmetic journey model
//               predicts stop times, level changes and dwell totals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_car_ctrl;

    localparam int T = 4;
    localparam int D = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] queue;
    logic [2:0] tail;
    logic       stop_at_pos_lvl;
    logic       door_hold;
    logic [1:0] pos_lvl;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic       arrive;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    elevator_car_ctrl #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .queue(queue), .tail(tail),
        .stop_at_pos_lvl(stop_at_pos_lvl), .door_hold(door_hold),
        .pos_lvl(pos_lvl), .moving(moving), .dir_up(dir_up),
        .door_open(door_open), .arrive(arrive)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Queue-side stop detection: car level matches any valid entry.
    always_comb begin
        stop_at_pos_lvl = 1'b0;
        for (int i = 0; i < 4; i++)
            if (int'(tail) > i && queue[2*i +: 2] == pos_lvl) stop_at_pos_lvl = 1'b1;
    end

    // Environment and model state
    logic [1:0] env_q[$];
    logic [1:0] mq[$];
    logic [1:0] m_pos;
    int ex_a_e[$], ex_a_l[$], ex_p_e[$], ex_p_l[$], ex_p_d[$];
    int ob_a_e[$], ob_a_l[$], ob_p_e[$], ob_p_l[$], ob_p_d[$];
    int ex_move, ex_door, e_end;

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic drive_queue();
        queue = 8'($urandom);
        tail  = 3'(env_q.size());
        for (int i = 0; i < env_q.size(); i++) queue[2*i +: 2] = env_q[i];
        if (env_q.size() == 4 && $urandom_range(0, 1) == 1) tail = 3'($urandom_range(5, 7));
    endtask

    function automatic bit in_mq(input logic [1:0] p);
        foreach (mq[i]) if (mq[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic rm_mq(input logic [1:0] p);
        logic [1:0] tmp[$];
        foreach (mq[i]) if (mq[i] != p) tmp.push_back(mq[i]);
        mq = tmp;
    endtask

    task automatic pop_env(input logic [1:0] p);
        logic [1:0] tmp[$];
        foreach (env_q[i]) if (env_q[i] != p) tmp.push_back(env_q[i]);
        env_q = tmp;
    endtask

    // Journey model: d is the edge at which an idle car decides.
    // Each level costs T+1 edges; a stop costs D+1 edges before the next decision.
    task automatic model(input int d0);
        int d, s;
        logic [1:0] p;
        mq = env_q; p = m_pos; d = d0;
        ex_a_e = {}; ex_a_l = {}; ex_p_e = {}; ex_p_l = {}; ex_p_d = {};
        ex_move = 0; ex_door = 0;
        while (mq.size() > 0) begin
            if (in_mq(p)) begin
                ex_a_e.push_back(d); ex_a_l.push_back(int'(p));
                rm_mq(p); ex_door += D; d += D + 1;
            end else begin
                s = (mq[0] > p) ? 1 : -1;
                while (1) begin
                    d += T + 1;
                    p = 2'(int'(p) + s);
                    ex_p_e.push_back(d - 1); ex_p_l.push_back(int'(p));
                    ex_p_d.push_back((s > 0) ? 1 : 0);
                    ex_move += T;
                    if (in_mq(p)) begin
                        ex_a_e.push_back(d); ex_a_l.push_back(int'(p));
                        rm_mq(p); ex_door += D; d += D + 1;
                        break;
                    end
                end
            end
        end
        m_pos = p; e_end = d;
    endtask

    // Load requests into an idle car, run until the model says it is parked, compare.
    task automatic run_scen(input string tag, input int n,
                            input logic [1:0] a0, input logic [1:0] a1,
                            input logic [1:0] a2, input logic [1:0] a3);
        logic [1:0] lv[4];
        logic [1:0] prev;
        int n_mv, n_dr, bad, lim;
        lv[0] = a0; lv[1] = a1; lv[2] = a2; lv[3] = a3;
        env_q = {};
        for (int i = 0; i < n; i++) env_q.push_back(lv[i]);
        drive_queue();
        model(cyc + 1);
        ob_a_e = {}; ob_a_l = {}; ob_p_e = {}; ob_p_l = {}; ob_p_d = {};
        n_mv = 0; n_dr = 0; bad = 0; prev = pos_lvl;
        lim = cyc + 2000;
        while (cyc < e_end + 2 && cyc < lim) begin
            @(negedge clk);
`ifndef DOOR_HOLD_EN
            door_hold = 1'($urandom_range(0, 1));
`endif
            if (moving) n_mv++;
            if (door_open) n_dr++;
            if (arrive && moving) bad++;
            if (pos_lvl != prev) begin
                ob_p_e.push_back(cyc); ob_p_l.push_back(int'(pos_lvl));
                ob_p_d.push_back(int'(dir_up));
                prev = pos_lvl;
            end
            if (arrive) begin
                ob_a_e.push_back(cyc); ob_a_l.push_back(int'(pos_lvl));
                pop_env(pos_lvl);
                drive_queue();
            end
        end
        chk({tag, "_timeout"}, int'(cyc >= lim), 0);
        chk({tag, "_n_arrive"}, ob_a_e.size(), ex_a_e.size());
        for (int i = 0; i < ex_a_e.size() && i < ob_a_e.size(); i++) begin
            chk({tag, "_arrive_edge"}, ob_a_e[i], ex_a_e[i]);
            chk({tag, "_arrive_lvl"}, ob_a_l[i], ex_a_l[i]);
        end
        chk({tag, "_n_steps"}, ob_p_e.size(), ex_p_e.size());
        for (int i = 0; i < ex_p_e.size() && i < ob_p_e.size(); i++) begin
            chk({tag, "_step_edge"}, ob_p_e[i], ex_p_e[i]);
            chk({tag, "_step_lvl"}, ob_p_l[i], ex_p_l[i]);
            chk({tag, "_step_dir"}, ob_p_d[i], ex_p_d[i]);
        end
        chk({tag, "_moving_cycles"}, n_mv, ex_move);
        chk({tag, "_door_cycles"}, n_dr, ex_door);
        chk({tag, "_arrive_while_moving"}, bad, 0);
        chk({tag, "_final_pos"}, int'(pos_lvl), int'(m_pos));
    endtask

    initial begin
        int n_mv, n_dr, n_ar, t0;
        reset = 1'b1; queue = 8'hA5; tail = 3'd3; door_hold = 1'b1;
        env_q = {}; m_pos = 2'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pos", int'(pos_lvl), 0);
        chk("rst_moving", int'(moving), 0);
        chk("rst_door", int'(door_open), 0);
        chk("rst_arrive", int'(arrive), 0);
        chk("rst_dir_up", int'(dir_up), 1);
        reset = 1'b0; door_hold = 1'b0; tail = 3'd0; queue = 8'h00;
        repeat (2) @(negedge clk);

        // A to D with single request, then D down serving B en route to A
        run_scen("a_to_d", 1, 2'd3, 2'd0, 2'd0, 2'd0);
        run_scen("d_to_b_to_a", 2, 2'd0, 2'd1, 2'd0, 2'd0);

        // Reset two cycles into a move
        env_q = {2'd3}; drive_queue();
        repeat (3) @(negedge clk);
        chk("pre_rst_moving", int'(moving), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_pos", int'(pos_lvl), 0);
        chk("mid_rst_moving", int'(moving), 0);
        chk("mid_rst_arrive", int'(arrive), 0);
        chk("mid_rst_door", int'(door_open), 0);
        chk("mid_rst_dir_up", int'(dir_up), 1);
        env_q = {}; drive_queue();
        @(negedge clk);
        reset = 1'b0; m_pos = 2'd0;
        @(negedge clk);

        // Stop at current level from idle: no movement
        run_scen("to_c", 1, 2'd2, 2'd0, 2'd0, 2'd0);
        run_scen("stop_here", 1, 2'd2, 2'd0, 2'd0, 2'd0);

        // Empty queue with junk contents stays parked
        tail = 3'd0; queue = 8'hFF; n_mv = 0; n_dr = 0; n_ar = 0;
        repeat (50) begin
            @(negedge clk);
            if (moving) n_mv++;
            if (door_open) n_dr++;
            if (arrive) n_ar++;
        end
        chk("empty_moving", n_mv, 0);
        chk("empty_door", n_dr, 0);
        chk("empty_arrive", n_ar, 0);
        chk("empty_pos", int'(pos_lvl), int'(m_pos));

        // Randomized request sets
        for (int k = 0; k < 25; k++) begin
            int n;
            n = $urandom_range(1, 4);
            run_scen("rand", n, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
        end

`ifdef DOOR_HOLD_EN
        // Door hold keeps the door open; closes D edges after the last held edge
        door_hold = 1'b0;
        env_q = {m_pos}; drive_queue();
        @(negedge clk);
        chk("hold_arrive", int'(arrive), 1);
        pop_env(pos_lvl); drive_queue();
        door_hold = 1'b1; n_dr = 0;
        repeat (10) begin
            @(negedge clk);
            if (door_open) n_dr++;
        end
        chk("hold_door_cycles", n_dr, 10);
        door_hold = 1'b0; t0 = cyc;
        while (door_open && cyc < t0 + 40) @(negedge clk);
        chk("hold_close_delay", cyc - t0, D);
`else
        t0 = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
